// File: rtl/cache_debug_resp.sv
// Cache-side debug responder: direct-mapped tag store plus word-addressed backing
// memory, answering single-cycle core requests with hit/miss-timed fin pulses.
//
// state  | meaning
// S_IDLE | no request in flight; accepts a strobe or starts a pending read
// S_WAIT | latency counter running; commit when it reaches its last cycle
module cache_debug_resp #(
   parameter int HIT_LAT  = 2,
   parameter int MISS_LAT = 8,
   parameter int MEM_AW   = 10
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        core2cache_rd_en,
   input  logic [26:0] core2cache_rd_addr,
   input  logic        core2cache_wr_en,
   input  logic [26:0] core2cache_wr_addr,
   input  logic [31:0] core2cache_wr_data,
   output logic        cache2core_rd_fin,
   output logic [31:0] cache2core_rd_data,
   output logic        cache2core_wr_fin,
   output logic        busy,
   output logic        protocol_err,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam logic [7:0] HIT_L  = 8'(HIT_LAT);
   localparam logic [7:0] MISS_L = 8'(MISS_LAT);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        op_wr_q;
   logic        hit_q;
   logic [26:2] addr_q;
   logic [31:0] data_q;
   logic        pend_q;
   logic [26:2] pend_addr_q;
   logic        rd_fin_q;
   logic        wr_fin_q;
   logic [31:0] rd_data_q;
   logic        perr_q;
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;
   logic [1023:0] valid_q;
   logic [12:0] tag_q [1024];
   logic [31:0] mem_q [2**MEM_AW];

   logic        st_go, st_wr, st_hit;
   logic [26:2] st_addr;
   logic [7:0]  st_lat;
   logic        cm_go, cm_wr, cm_hit;
   logic [26:2] cm_addr;
   logic [31:0] cm_data;
   logic [9:0]  st_idx, cm_idx;
   logic [MEM_AW-1:0] cm_word;
   logic        strobe;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{core2cache_rd_addr[1:0], core2cache_wr_addr[1:0]};
   assign strobe = core2cache_rd_en | core2cache_wr_en;

   // A pending read outranks new strobes; a write outranks a simultaneous read.
   always_comb begin
      st_go   = 1'b0;
      st_wr   = 1'b0;
      st_addr = core2cache_rd_addr[26:2];
      if (state_q == S_IDLE) begin
         if (pend_q) begin
            st_go   = 1'b1;
            st_addr = pend_addr_q;
         end else if (core2cache_wr_en) begin
            st_go   = 1'b1;
            st_wr   = 1'b1;
            st_addr = core2cache_wr_addr[26:2];
         end else if (core2cache_rd_en) begin
            st_go   = 1'b1;
         end
      end
      st_idx = st_addr[13:4];
      st_hit = valid_q[st_idx] && (tag_q[st_idx] == st_addr[26:14]);
      st_lat = st_hit ? HIT_L : MISS_L;

      cm_go   = 1'b0;
      cm_wr   = op_wr_q;
      cm_hit  = hit_q;
      cm_addr = addr_q;
      cm_data = data_q;
      if (state_q == S_WAIT && cnt_q == 8'd1) begin
         cm_go = 1'b1;
      end else if (st_go && st_lat == 8'd1) begin
         cm_go   = 1'b1;
         cm_wr   = st_wr;
         cm_hit  = st_hit;
         cm_addr = st_addr;
         cm_data = core2cache_wr_data;
      end
      cm_idx  = cm_addr[13:4];
      cm_word = cm_addr[MEM_AW+1:2];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         hit_q       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         rd_fin_q    <= 1'b0;
         wr_fin_q    <= 1'b0;
         rd_data_q   <= '0;
         perr_q      <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         valid_q     <= '0;
      end else begin
         rd_fin_q <= cm_go && !cm_wr;
         wr_fin_q <= cm_go && cm_wr;
         if (cm_go && !cm_wr)
            rd_data_q <= mem_q[cm_word];
         if (cm_go) begin
            valid_q[cm_idx] <= 1'b1;
            if (cm_hit) begin
               if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
               if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
         end
         if (strobe && (state_q == S_WAIT || pend_q))
            perr_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (st_go && !cm_go) begin
                  state_q <= S_WAIT;
                  cnt_q   <= st_lat - 8'd1;
                  op_wr_q <= st_wr;
                  hit_q   <= st_hit;
                  addr_q  <= st_addr;
                  data_q  <= core2cache_wr_data;
               end
               if (pend_q) begin
                  pend_q <= 1'b0;
               end else if (core2cache_wr_en && core2cache_rd_en) begin
                  pend_q      <= 1'b1;
                  pend_addr_q <= core2cache_rd_addr[26:2];
               end
            end
            S_WAIT: begin
               if (cm_go) state_q <= S_IDLE;
               else       cnt_q   <= cnt_q - 8'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Storage arrays carry no reset: contents survive rstn.
   always_ff @(posedge clk) begin
      if (cm_go && cm_wr)
         mem_q[cm_word] <= cm_data;
   end

   always_ff @(posedge clk) begin
      if (cm_go)
         tag_q[cm_idx] <= cm_addr[26:14];
   end

   assign cache2core_rd_fin  = rd_fin_q;
   assign cache2core_wr_fin  = wr_fin_q;
   assign cache2core_rd_data = rd_data_q;
   assign busy               = (state_q == S_WAIT) || pend_q;
   assign protocol_err       = perr_q;
   assign hit_count          = hit_cnt_q;
   assign miss_count         = miss_cnt_q;

endmodule

// File: tb/tb_cache_debug_resp.sv
// Bench for cache_debug_resp: transaction-level cache model feeding a per-cycle
// expectation timeline, plus directed scenarios with literal checks.
module tb_cache_debug_resp;

   localparam int HIT_LAT  = 2;
   localparam int MISS_LAT = 8;
   localparam int MEM_AW   = 10;
   localparam int MAXC     = 2048;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [26:0] rd_addr = '0, wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        rd_fin, wr_fin, busy, perr;
   logic [31:0] rd_data;
   logic [15:0] hit_count, miss_count;

   cache_debug_resp #(.HIT_LAT(HIT_LAT), .MISS_LAT(MISS_LAT), .MEM_AW(MEM_AW)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .core2cache_rd_en  (rd_en),
      .core2cache_rd_addr(rd_addr),
      .core2cache_wr_en  (wr_en),
      .core2cache_wr_addr(wr_addr),
      .core2cache_wr_data(wr_data),
      .cache2core_rd_fin (rd_fin),
      .cache2core_rd_data(rd_data),
      .cache2core_wr_fin (wr_fin),
      .busy              (busy),
      .protocol_err      (perr),
      .hit_count         (hit_count),
      .miss_count        (miss_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_mis = 0;

   // cache model state
   bit          m_valid [1024];
   logic [12:0] m_tag   [1024];
   logic [31:0] m_mem   [2**MEM_AW];
   int          free_cyc;
   int          busy_lo, busy_hi;
   // expectation timeline, indexed by cycle
   bit          ev_rdf [MAXC];
   bit          ev_wrf [MAXC];
   bit          ev_perr[MAXC];
   int          ev_hit [MAXC];
   int          ev_miss[MAXC];
   logic [31:0] ev_rdd [MAXC];
   logic [31:0] e_rdd;
   bit          e_perr;
   int          e_hit, e_miss;
   // pending memory writes that a reset could still cancel
   int          u_fin[$];
   int          u_idx[$];
   logic [31:0] u_old[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_op(input bit wr, input logic [26:0] a, input logic [31:0] d,
                           input int start, output int fin);
      int idx, w;
      bit hit;
      idx = int'(a[13:4]);
      w   = int'(a[MEM_AW+1:2]);
      hit = m_valid[idx] && (m_tag[idx] == a[26:14]);
      fin = start + (hit ? HIT_LAT : MISS_LAT);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[26:14];
      if (wr) begin
         u_fin.push_back(fin);
         u_idx.push_back(w);
         u_old.push_back(m_mem[w]);
         m_mem[w]    = d;
         ev_wrf[fin] = 1'b1;
      end else begin
         ev_rdf[fin] = 1'b1;
         ev_rdd[fin] = m_mem[w];
      end
      if (hit) ev_hit[fin]++;
      else     ev_miss[fin]++;
   endtask

   task automatic model_reset(input int r);
      for (int t = r; t < MAXC; t++) begin
         ev_rdf[t] = 0; ev_wrf[t] = 0; ev_perr[t] = 0;
         ev_hit[t] = 0; ev_miss[t] = 0; ev_rdd[t] = '0;
      end
      for (int i = u_fin.size() - 1; i >= 0; i--)
         if (u_fin[i] > r) m_mem[u_idx[i]] = u_old[i];
      u_fin.delete(); u_idx.delete(); u_old.delete();
      for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
      e_rdd = '0; e_perr = 0; e_hit = 0; e_miss = 0;
      busy_lo = 1; busy_hi = 0;
      free_cyc = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic at_neg(input int t);
      run_to(t);
      @(negedge clk);
   endtask

   // Drive one strobe cycle at the current cycle and tell the model about it.
   task automatic issue(input bit rd, input bit wr, input logic [26:0] ra,
                        input logic [26:0] wa, input logic [31:0] wd);
      int c, f;
      c = cyc;
      rd_en = rd; wr_en = wr; rd_addr = ra; wr_addr = wa; wr_data = wd;
      if (c < free_cyc) begin
         ev_perr[c+1] = 1'b1;
      end else begin
         f = c;
         if (wr) model_op(1'b1, wa, wd, c, f);
         if (rd) model_op(1'b0, ra, '0, f, f);
         busy_lo  = c + 1;
         busy_hi  = f - 1;
         free_cyc = f;
      end
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         if (ev_rdf[cyc]) e_rdd = ev_rdd[cyc];
         if (ev_perr[cyc]) e_perr = 1'b1;
         e_hit  = (e_hit  + ev_hit[cyc]  > 65535) ? 65535 : e_hit  + ev_hit[cyc];
         e_miss = (e_miss + ev_miss[cyc] > 65535) ? 65535 : e_miss + ev_miss[cyc];
         chk("rd_fin", {31'd0, rd_fin}, {31'd0, ev_rdf[cyc]});
         chk("wr_fin", {31'd0, wr_fin}, {31'd0, ev_wrf[cyc]});
         chk("rd_data", rd_data, e_rdd);
         chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
         chk("protocol_err", {31'd0, perr}, {31'd0, e_perr});
         chk("hit_count", {16'd0, hit_count}, 32'(e_hit));
         chk("miss_count", {16'd0, miss_count}, 32'(e_miss));
      end
   end

   initial begin
      int c;
      for (int i = 0; i < 2**MEM_AW; i++) m_mem[i] = '0;
      model_reset(0);
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // cold write miss
      c = cyc;
      issue(0, 1, '0, 27'h0000000, 32'h0000FFFF);
      at_neg(c + 7);
      chk("cold_wr_fin_early", {31'd0, wr_fin}, 32'd0);
      at_neg(c + 8);
      chk("cold_wr_fin", {31'd0, wr_fin}, 32'd1);
      chk("cold_busy", {31'd0, busy}, 32'd0);
      chk("cold_miss", {16'd0, miss_count}, 32'd1);

      // read hit, issued in the write's fin cycle
      c = cyc;
      issue(1, 0, 27'h0000000, '0, '0);
      at_neg(c + 2);
      chk("hit_rd_fin", {31'd0, rd_fin}, 32'd1);
      chk("hit_rd_data", rd_data, 32'h0000FFFF);
      chk("hit_count1", {16'd0, hit_count}, 32'd1);
      at_neg(c + 5);
      chk("hit_rd_data_held", rd_data, 32'h0000FFFF);

      // eviction: same index 4, different tags
      tick();
      c = cyc;
      issue(0, 1, '0, 27'h0000044, 32'h0000FF00);
      run_to(c + 8);
      issue(0, 1, '0, 27'h0100040, 32'h00009999);
      run_to(c + 16);
      issue(1, 0, 27'h0000044, '0, '0);
      at_neg(c + 24);
      chk("evict_rd_fin", {31'd0, rd_fin}, 32'd1);
      chk("evict_rd_data", rd_data, 32'h0000FF00);
      chk("evict_miss", {16'd0, miss_count}, 32'd4);

      // word alias: 0x1044 shares the word of 0x44 but not its cache line
      tick();
      c = cyc;
      issue(0, 1, '0, 27'h0001044, 32'h00005555);
      run_to(c + 8);
      issue(1, 0, 27'h0000044, '0, '0);
      at_neg(c + 10);
      chk("alias_rd_fin", {31'd0, rd_fin}, 32'd1);
      chk("alias_rd_data", rd_data, 32'h00005555);
      chk("alias_hits", {16'd0, hit_count}, 32'd2);

      // simultaneous read and write to an uncached line
      tick();
      c = cyc;
      issue(1, 1, 27'h0000080, 27'h0000080, 32'h00001234);
      at_neg(c + 8);
      chk("sim_wr_fin", {31'd0, wr_fin}, 32'd1);
      chk("sim_rd_fin_not_yet", {31'd0, rd_fin}, 32'd0);
      at_neg(c + 10);
      chk("sim_rd_fin", {31'd0, rd_fin}, 32'd1);
      chk("sim_rd_data", rd_data, 32'h00001234);
      chk("sim_counts", {hit_count, miss_count}, {16'd3, 16'd6});

      // strobe during an in-flight miss
      tick();
      c = cyc;
      issue(0, 1, '0, 27'h0008000, 32'h00000077);
      run_to(c + 3);
      issue(0, 1, '0, 27'h0000000, 32'hDEADBEEF);
      at_neg(c + 4);
      chk("perr_set", {31'd0, perr}, 32'd1);
      at_neg(c + 8);
      chk("perr_orig_wr_fin", {31'd0, wr_fin}, 32'd1);
      at_neg(c + 15);
      chk("perr_sticky", {31'd0, perr}, 32'd1);

      // reset in the middle of a miss write aliasing the 0x80 word
      tick();
      c = cyc;
      issue(0, 1, '0, 27'h0004080, 32'h0000AAAA);
      run_to(c + 3);
      rstn = 1'b0;
      model_reset(c + 3);
      @(negedge clk);
      chk("rst_outputs", {rd_fin, wr_fin, busy, perr}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_counts", {hit_count, miss_count}, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      tick();
      c = cyc;
      issue(1, 0, 27'h0000080, '0, '0);
      at_neg(c + 2);
      chk("post_rst_no_hit", {31'd0, rd_fin}, 32'd0);
      at_neg(c + 8);
      chk("post_rst_rd_fin", {31'd0, rd_fin}, 32'd1);
      chk("post_rst_rd_data", rd_data, 32'h00001234);
      chk("post_rst_miss", {16'd0, miss_count}, 32'd1);

      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
